// File: rtl/snn_apb_csr.sv
// snn_apb_csr: APB slave control/status register block for the SNN core.
// It terminates the APB bus and adds WAIT_CYCLES wait states (pready low)
// before it completes each transfer.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   psel .. pwdata    APB slave inputs
//   prdata, pready    APB slave outputs (registered)
//   snn_enable        CTRL[0] level
//   snn_start         one-cycle start pulse after a CTRL write with bit 1 set
//   snn_thresh        neuron firing threshold
//   snn_leak          membrane leak value
//   snn_busy          core running (status input)
//   snn_done          one-cycle done pulse from the core
//   snn_ovf           one-cycle membrane overflow pulse from the core
//   snn_spike_cnt     live spike counter from the core
//   irq               level interrupt, |(IRQ_STATUS & IRQ_EN), registered
module snn_apb_csr #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h534E_4E01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        snn_enable,
  output logic        snn_start,
  output logic [15:0] snn_thresh,
  output logic [7:0]  snn_leak,
  input  logic        snn_busy,
  input  logic        snn_done,
  input  logic        snn_ovf,
  input  logic [31:0] snn_spike_cnt,
  output logic        irq
);

  localparam bit        NoWait   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WaitInit = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        enter_ready;

  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        ctrl_en_q, ctrl_en_d;
  logic        start_q, start_d;
  logic [15:0] thresh_q, thresh_d;
  logic [7:0]  leak_q, leak_d;
  logic [2:0]  irq_st_q, irq_st_d;
  logic [2:0]  irq_en_q, irq_en_d;
  logic        irq_q, irq_d;

  logic        addr_hit;
  logic [2:0]  reg_idx;
  logic [31:0] rd_val;
  logic        commit;
  logic        wr_ctrl, wr_thresh, wr_leak, wr_irq_st, wr_irq_en;
  logic        start_err;
  logic [2:0]  w1c_mask;

  // Address bits [1:0] and upper write-data bits are not part of any register.
  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], pwdata[31:16]};

  assign addr_hit = (paddr[31:5] == 27'd0);
  assign reg_idx  = paddr[4:2];

  // Read mux; unmapped/out-of-range addresses read 0.
  always_comb begin
    rd_val = 32'd0;
    if (addr_hit) begin
      unique case (reg_idx)
        3'd0:    rd_val = {31'd0, ctrl_en_q};
        3'd1:    rd_val = {16'd0, thresh_q};
        3'd2:    rd_val = {24'd0, leak_q};
        3'd3:    rd_val = {31'd0, snn_busy};
        3'd4:    rd_val = {29'd0, irq_st_q};
        3'd5:    rd_val = {29'd0, irq_en_q};
        3'd6:    rd_val = snn_spike_cnt;
        3'd7:    rd_val = ID_VALUE;
        default: rd_val = 32'd0;
      endcase
    end
  end

  // Transfer FSM; cnt counts down the remaining wait cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enter_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          if (NoWait) begin
            state_d     = StReady;
            enter_ready = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (!psel) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d     = StReady;
          enter_ready = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StReady: begin
        // psel&penable completes the transfer; a dropped psel aborts it.
        if (!psel || penable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign commit    = (state_q == StReady) && psel && penable && pwrite && addr_hit;
  assign wr_ctrl   = commit && (reg_idx == 3'd0);
  assign wr_thresh = commit && (reg_idx == 3'd1);
  assign wr_leak   = commit && (reg_idx == 3'd2);
  assign wr_irq_st = commit && (reg_idx == 3'd4);
  assign wr_irq_en = commit && (reg_idx == 3'd5);

  assign start_err = wr_ctrl && pwdata[1] && snn_busy;
  assign w1c_mask  = wr_irq_st ? pwdata[2:0] : 3'b000;

  always_comb begin
    pready_d  = (state_d == StReady);
    prdata_d  = prdata_q;
    // Read data (including the live spike count) is captured on entry to READY.
    if (enter_ready) prdata_d = pwrite ? 32'd0 : rd_val;
    ctrl_en_d = wr_ctrl ? pwdata[0] : ctrl_en_q;
    start_d   = wr_ctrl && pwdata[1] && !snn_busy;
    thresh_d  = wr_thresh ? pwdata[15:0] : thresh_q;
    leak_d    = wr_leak ? pwdata[7:0] : leak_q;
    irq_en_d  = wr_irq_en ? pwdata[2:0] : irq_en_q;
    // Hardware set is applied after the W1C clear so a same-cycle set wins.
    irq_st_d  = (irq_st_q & ~w1c_mask) | {start_err, snn_ovf, snn_done};
    irq_d     = |(irq_st_q & irq_en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      prdata_q  <= 32'd0;
      pready_q  <= 1'b0;
      ctrl_en_q <= 1'b0;
      start_q   <= 1'b0;
      thresh_q  <= 16'h0100;
      leak_q    <= 8'h01;
      irq_st_q  <= 3'b000;
      irq_en_q  <= 3'b000;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      ctrl_en_q <= ctrl_en_d;
      start_q   <= start_d;
      thresh_q  <= thresh_d;
      leak_q    <= leak_d;
      irq_st_q  <= irq_st_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign snn_enable = ctrl_en_q;
  assign snn_start  = start_q;
  assign snn_thresh = thresh_q;
  assign snn_leak   = leak_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_snn_apb_csr.sv
module tb_snn_apb_csr;

  localparam int unsigned WaitCycles = 1;
  localparam logic [31:0] IdValue    = 32'h534E_4E01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready;
  logic        snn_enable, snn_start;
  logic [15:0] snn_thresh;
  logic [7:0]  snn_leak;
  logic        snn_busy, snn_done, snn_ovf;
  logic [31:0] snn_spike_cnt;
  logic        irq;

  always #5 clk = ~clk;

  snn_apb_csr #(
    .WAIT_CYCLES(WaitCycles),
    .ID_VALUE   (IdValue)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .snn_enable   (snn_enable),
    .snn_start    (snn_start),
    .snn_thresh   (snn_thresh),
    .snn_leak     (snn_leak),
    .snn_busy     (snn_busy),
    .snn_done     (snn_done),
    .snn_ovf      (snn_ovf),
    .snn_spike_cnt(snn_spike_cnt),
    .irq          (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference register state.
  bit          m_en;
  logic [15:0] m_thresh;
  logic [7:0]  m_leak;
  logic [2:0]  m_st;
  logic [2:0]  m_ien;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_thresh = 16'h0100; m_leak = 8'h01; m_st = 3'd0; m_ien = 3'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (addr >= 32'h20) return 32'd0;
    case (addr / 4)
      0: return m_en ? 32'd1 : 32'd0;
      1: return 32'(m_thresh);
      2: return 32'(m_leak);
      3: return snn_busy ? 32'd1 : 32'd0;
      4: return 32'(m_st);
      5: return 32'(m_ien);
      6: return snn_spike_cnt;
      default: return IdValue;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input bit done_now, output bit exp_start);
    logic [2:0] clr;
    logic [2:0] set;
    exp_start = 1'b0;
    clr = 3'd0;
    set = done_now ? 3'b001 : 3'b000;
    if (addr < 32'h20) begin
      case (addr / 4)
        0: begin
          m_en = data[0];
          if (data[1]) begin
            if (snn_busy) set[2] = 1'b1;
            else exp_start = 1'b1;
          end
        end
        1: m_thresh = data[15:0];
        2: m_leak = data[7:0];
        4: clr = data[2:0];
        5: m_ien = data[2:0];
        default: ;
      endcase
    end
    m_st = (m_st & ~clr) | set;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_enable"}, 32'(snn_enable), m_en ? 32'd1 : 32'd0);
    check({tag, "_thresh"}, 32'(snn_thresh), 32'(m_thresh));
    check({tag, "_leak"}, 32'(snn_leak), 32'(m_leak));
  endtask

  // Called at posedge+1 with the bus idle; returns at commit edge +1.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input bit done_at_commit, output logic [31:0] rdata);
    int waits;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (pready !== 1'b1 && waits < 40) begin
      waits++;
      @(posedge clk); #1;
    end
    check("pready_wait", 32'(waits), 32'(WaitCycles));
    rdata = prdata;
    if (done_at_commit) snn_done = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; snn_done = 1'b0;
    check("pready_drop", 32'(pready), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit done_now);
    logic [31:0] rd;
    bit exp_start;
    apb(1'b1, addr, data, done_now, rd);
    model_write(addr, data, done_now, exp_start);
    check("start_pulse", 32'(snn_start), exp_start ? 32'd1 : 32'd0);
    check_outs("wr");
    @(posedge clk); #1;
    check("start_low", 32'(snn_start), 32'd0);
    check("irq_wr", 32'(irq), (|(m_st & m_ien)) ? 32'd1 : 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr);
    logic [31:0] rd;
    logic [31:0] exp;
    exp = model_read(addr);
    apb(1'b0, addr, 32'd0, 1'b0, rd);
    check(tag, rd, exp);
  endtask

  task automatic hw_pulse(input bit d, input bit o);
    snn_done = d; snn_ovf = o;
    @(posedge clk); #1;
    snn_done = 1'b0; snn_ovf = 1'b0;
    m_st = m_st | {1'b0, o, d};
    @(posedge clk); #1;
    check("irq_hw", 32'(irq), (|(m_st & m_ien)) ? 32'd1 : 32'd0);
  endtask

  logic [31:0] addr_tbl [11] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                                 32'h1C, 32'h20, 32'h1000_0008, 32'h03};

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    snn_busy = 1'b0; snn_done = 1'b0; snn_ovf = 1'b0; snn_spike_cnt = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_start", 32'(snn_start), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check_outs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset-value readback.
    do_read("rd_id", 32'h1C);
    do_read("rd_thresh_rst", 32'h04);
    do_read("rd_leak_rst", 32'h08);

    // Threshold write keeps only the low half.
    do_write(32'h04, 32'hFFFF_1234, 1'b0);
    do_read("rd_thresh", 32'h04);

    // Start with core idle, then with core busy.
    do_write(32'h00, 32'h3, 1'b0);
    snn_busy = 1'b1;
    do_write(32'h00, 32'h3, 1'b0);
    do_read("rd_irq_st_err", 32'h10);
    do_read("rd_status", 32'h0C);
    snn_busy = 1'b0;

    // Interrupt path, including set-beats-clear.
    do_write(32'h10, 32'h7, 1'b0);
    do_write(32'h14, 32'h7, 1'b0);
    hw_pulse(1'b1, 1'b0);
    do_read("rd_irq_st_done", 32'h10);
    do_write(32'h10, 32'h1, 1'b1);
    do_read("rd_irq_st_keep", 32'h10);
    do_write(32'h10, 32'h1, 1'b0);
    check("irq_cleared", 32'(irq), 32'd0);

    // Unmapped address.
    do_read("rd_unmapped", 32'h20);
    do_write(32'h20, 32'hFFFF_FFFF, 1'b0);

    // psel dropped during WAIT: the leak write is abandoned.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hAB;
    @(posedge clk); #1;
    penable = 1'b1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("abort_pready", 32'(pready), 32'd0);
    @(posedge clk); #1;
    check("abort_leak", 32'(snn_leak), 32'(m_leak));
    do_read("rd_leak_abort", 32'h08);

    // Reset during WAIT of a threshold write.
    do_write(32'h04, 32'h0000_0777, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5555;
    @(posedge clk); #1;
    penable = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rstmid_pready", 32'(pready), 32'd0);
    check("rstmid_thresh", 32'(snn_thresh), 32'h0100);
    psel = 1'b0; penable = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read("rd_thresh_rstmid", 32'h04);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      int r;
      logic [31:0] a;
      snn_busy = 1'($urandom_range(0, 1));
      snn_spike_cnt = $urandom;
      a = addr_tbl[$urandom_range(0, 10)];
      r = $urandom_range(0, 9);
      if (r < 4) do_write(a, $urandom, ($urandom_range(0, 3) == 0));
      else if (r < 8) do_read("rnd_rd", a);
      else hw_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check_outs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_apb_csr.md
Name: snn_apb_csr

Overview:
APB slave control/status register block. It terminates the APB bus driven by the testbench APB agent and exposes SNN core configuration (enable, start, threshold, leak) plus status, spike count and interrupt logic. It sits between the APB bus and the SNN core. It inserts a configurable number of wait states via pready.

Parameters:
WAIT_CYCLES, 1, number of access-phase cycles with pready low before pready rises (0..15)
ID_VALUE, 32'h534E_4E01, read-only value returned at ID register

Ports:
clk  input  1  single design clock
rst_n  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1=write, 0=read
paddr  input  32  byte address; only paddr[4:2] decoded, paddr[31:5] must be zero to hit
pwdata  input  32  write data
prdata  output  32  read data, valid while pready=1
pready  output  1  transfer complete
snn_enable  output  1  CTRL[0] level
snn_start  output  1  one-cycle start pulse
snn_thresh  output  16  neuron firing threshold
snn_leak  output  8  membrane leak value
snn_busy  input  1  core running
snn_done  input  1  one-cycle done pulse from core
snn_ovf  input  1  one-cycle membrane overflow pulse
snn_spike_cnt  input  32  live spike counter from core
irq  output  1  level interrupt

Behaviour:
- Clock/reset: one clock; reset asynchronous, active-low (rst_n). All outputs registered.
- Reset values: prdata=0, pready=0, snn_enable=0, snn_start=0, snn_thresh=16'h0100, snn_leak=8'h01, irq=0, IRQ_STATUS=0, IRQ_EN=0. FSM goes to IDLE.
- FSM: IDLE, WAIT, READY.
  - IDLE -> WAIT (cnt loaded with WAIT_CYCLES-1) when psel=1 and penable=0. If WAIT_CYCLES=0, go directly to READY.
  - WAIT decrements cnt; -> READY when cnt=0 at the edge.
  - READY: pready=1 and prdata holds the read value. On the edge with psel&penable=1, a write commits; -> IDLE.
- Access-phase length is WAIT_CYCLES+1 cycles.
- psel dropping in WAIT or READY: -> IDLE, no commit, pready=0 next cycle.
- Register map (byte offset):
  - 0x00 CTRL RW: [0] enable, [1] start (write-1 pulse, reads 0).
  - 0x04 THRESH RW [15:0].
  - 0x08 LEAK RW [7:0].
  - 0x0C STATUS RO: [0] snn_busy.
  - 0x10 IRQ_STATUS W1C: [0] done, [1] ovf, [2] start_err.
  - 0x14 IRQ_EN RW [2:0].
  - 0x18 SPIKE_CNT RO, sampled into prdata on WAIT->READY (or IDLE->READY).
  - 0x1C ID RO.
- Unused bits read 0. Unmapped or out-of-range address: read returns 0, write ignored, pready still asserted normally.
- snn_start: high exactly one cycle, the cycle after a CTRL commit with pwdata[1]=1, if snn_busy=0 at commit. If snn_busy=1, no pulse and IRQ_STATUS[2] is set.
- IRQ_STATUS bits set on snn_done/snn_ovf pulses. If a hardware set and a W1C clear hit the same bit in the same cycle, set wins.
- irq = |(IRQ_STATUS & IRQ_EN), registered (one cycle after status/enable change).
- Reset asserted mid-transfer: immediate return to reset values; in-flight write is lost.

Test Plan:
- Reset then read 0x1C, 0x04, 0x08 -> 32'h534E4E01, 32'h00000100, 32'h00000001. With WAIT_CYCLES=1, pready low 1 access cycle then high 1 cycle.
- Write 0x04=32'hFFFF_1234, read back -> snn_thresh=16'h1234 the cycle after the commit edge; readback 32'h00001234.
- Write CTRL=32'h3 with snn_busy=0 -> snn_enable=1, snn_start high exactly 1 cycle. Repeat with snn_busy=1 -> no pulse, IRQ_STATUS=32'h4.
- IRQ_EN=7, pulse snn_done -> IRQ_STATUS=1, irq=1. Write 0x10=1 on the same cycle as another snn_done pulse -> bit stays 1. Clear again with no pulse -> irq=0 one cycle later.
- Read 0x20 and write 0x20 -> prdata=0, no register changes, pready asserted after WAIT_CYCLES. Deassert psel during WAIT on a write to 0x08 -> LEAK unchanged.
- Assert rst_n=0 during WAIT of a write to 0x04 -> pready=0 and snn_thresh=16'h0100 immediately. The write is not applied.
